siso_frame_deser: RTL and testbench

Serial frame deserializer that sits directly downstream of the 4-bit SISO shift-right register and consumes its `sout` bit stream. It hunts for a start bit, then shifts in `DATA_W` data bits LSB-first, an optional even-parity bit and a stop bit. It presents each received word on a registered valid/ready output with parity and framing error flags. Idle line level is 0, matching the SISO's all-zero reset state.

---
 rtl/siso_pkg.sv | 29 ++
 rtl/siso_out_buf.sv | 67 ++++++
 rtl/siso_frame_deser.sv | 125 ++++++++++++
 tb/tb_siso_frame_deser.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/siso_pkg.sv
// ============================================================================
//  Module      : siso_pkg
//  Description : Shared types and constants for the SISO frame deserializer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package siso_pkg;

  // Receiver FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } deser_state_t;

  // Line levels: the SISO resets to all zeros, so 0 is idle and 1 marks a start bit
  localparam logic LINE_IDLE  = 1'b0;
  localparam logic LINE_START = 1'b1;

  // Width of a counter that can hold 0..data_w
  function automatic int deser_cnt_w(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/siso_out_buf.sv
// ============================================================================
//  Module      : siso_out_buf
//  Description : Single-entry valid/ready holding register for received
//                words, with overrun detection on a full, non-draining buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module siso_out_buf #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmpl,
  input  logic [DATA_W-1:0] cmpl_data,
  input  logic              cmpl_perr,
  input  logic              cmpl_ferr,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_perr,
  output logic              out_ferr,
  output logic              ovr
);

  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_perr;
  logic              r_ferr;
  logic              r_ovr;
  logic              w_load;
  logic              w_drop;

  // A completion can land when the slot is empty or being drained on this edge
  assign w_load = cmpl & (~r_valid | out_ready);
  assign w_drop = cmpl & r_valid & ~out_ready;

  // Holding register: load on completion, clear valid on a plain acceptance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_ovr   <= 1'b0;
    end else begin
      r_ovr <= w_drop;
      if (w_load) begin
        r_data  <= cmpl_data;
        r_perr  <= cmpl_perr;
        r_ferr  <= cmpl_ferr;
        r_valid <= 1'b1;
      end else if (r_valid && out_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_data;
  assign out_valid = r_valid;
  assign out_perr  = r_perr;
  assign out_ferr  = r_ferr;
  assign ovr       = r_ovr;

endmodule

`default_nettype wire

// File: rtl/siso_frame_deser.sv
// ============================================================================
//  Module      : siso_frame_deser
//  Description : Serial frame deserializer: start bit, DATA_W data bits
//                LSB-first, optional even parity, stop bit. Presents words on
//                a registered valid/ready output with parity/framing flags.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module siso_frame_deser
  import siso_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int PARITY_EN = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_en,
  input  logic              sin,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_perr,
  output logic              out_ferr,
  output logic              ovr,
  output logic              busy
);

  localparam int              CNT_W  = deser_cnt_w(DATA_W);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DATA_W - 1);

  deser_state_t      r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [DATA_W-1:0] r_shreg, w_shreg_nxt;
  logic              r_par, w_par_nxt;
  logic              r_perr, w_perr_nxt;
  logic              r_busy;
  logic              w_cmpl;
  logic              w_ferr;
  logic              w_perr_out;

  // State and datapath registers; everything only moves via the next-state logic
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_shreg <= '0;
      r_par   <= 1'b0;
      r_perr  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_shreg <= w_shreg_nxt;
      r_par   <= w_par_nxt;
      r_perr  <= w_perr_nxt;
      r_busy  <= (w_state_nxt != IDLE);
    end
  end

  // Next-state / datapath logic; nothing advances unless the bit strobe is high
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shreg_nxt = r_shreg;
    w_par_nxt   = r_par;
    w_perr_nxt  = r_perr;
    w_cmpl      = 1'b0;
    w_ferr      = (sin != LINE_IDLE);
    if (bit_en) begin
      unique case (r_state)
        IDLE: begin
          if (sin == LINE_START) begin
            w_cnt_nxt   = '0;
            w_par_nxt   = 1'b0;
            w_perr_nxt  = 1'b0;
            w_state_nxt = DATA;
          end
        end
        DATA: begin
          w_shreg_nxt = {sin, r_shreg[DATA_W-1:1]};
          w_cnt_nxt   = r_cnt + 1'b1;
          w_par_nxt   = r_par ^ sin;
          if (r_cnt == C_LAST) begin
            w_state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
          end
        end
        PARITY: begin
          w_perr_nxt  = r_par ^ sin;
          w_state_nxt = STOP;
        end
        STOP: begin
          w_cmpl      = 1'b1;
          w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // With parity disabled the error flag is tied low
  assign w_perr_out = (PARITY_EN != 0) ? r_perr : 1'b0;

  siso_out_buf #(
    .DATA_W (DATA_W)
  ) u_out_buf (
    .clk       (clk),
    .rst       (rst),
    .cmpl      (w_cmpl),
    .cmpl_data (r_shreg),
    .cmpl_perr (w_perr_out),
    .cmpl_ferr (w_ferr),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_perr  (out_perr),
    .out_ferr  (out_ferr),
    .ovr       (ovr)
  );

  assign busy = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_siso_frame_deser.sv
// ============================================================================
//  Module      : tb_siso_frame_deser
//  Description : Directed self-checking bench for siso_frame_deser.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_siso_frame_deser;

  logic       clk;
  logic       rst;
  logic       bit_en;
  logic       sin;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_perr;
  logic       out_ferr;
  logic       ovr;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  siso_frame_deser #(
    .DATA_W    (8),
    .PARITY_EN (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bit_en    (bit_en),
    .sin       (sin),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_perr  (out_perr),
    .out_ferr  (out_ferr),
    .ovr       (ovr),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for every check
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One strobed bit, then `gap` unstrobed cycles carrying the inverted level
  task automatic send_bit(input logic b, input int gap);
    sin    = b;
    bit_en = 1'b1;
    @(posedge clk); #1;
    for (int g = 0; g < gap; g++) begin
      bit_en = 1'b0;
      sin    = ~b;
      @(posedge clk); #1;
    end
  endtask

  // Start bit, data LSB-first and parity bit
  task automatic send_body(input logic [7:0] d, input logic p, input int gap);
    send_bit(1'b1, gap);
    for (int i = 0; i < 8; i++) send_bit(d[i], gap);
    send_bit(p, gap);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int gap);
    send_body(d, p, gap);
    send_bit(s, gap);
  endtask

  task automatic idle(input int n);
    sin    = 1'b0;
    bit_en = 1'b1;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst       = 1'b1;
    bit_en    = 1'b0;
    sin       = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_data",  16'(out_data), 16'h00);
    check("rst_valid", 16'(out_valid), 16'h0);
    check("rst_perr",  16'(out_perr), 16'h0);
    check("rst_ferr",  16'(out_ferr), 16'h0);
    check("rst_ovr",   16'(ovr), 16'h0);
    check("rst_busy",  16'(busy), 16'h0);
    rst = 1'b0;
    idle(2);
    check("idle_busy", 16'(busy), 16'h0);

    // Basic byte A5, valid exactly after the 11th edge
    out_ready = 1'b1;
    send_bit(1'b1, 0);
    check("basic_busy_start", 16'(busy), 16'h1);
    send_bit(1'b1, 0); send_bit(1'b0, 0); send_bit(1'b1, 0); send_bit(1'b0, 0);
    send_bit(1'b0, 0); send_bit(1'b1, 0); send_bit(1'b0, 0); send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    check("basic_valid_early", 16'(out_valid), 16'h0);
    send_bit(1'b0, 0);
    check("basic_valid", 16'(out_valid), 16'h1);
    check("basic_data",  16'(out_data), 16'h00A5);
    check("basic_perr",  16'(out_perr), 16'h0);
    check("basic_ferr",  16'(out_ferr), 16'h0);
    check("basic_busy_end", 16'(busy), 16'h0);
    idle(1);
    check("basic_accept_valid", 16'(out_valid), 16'h0);
    check("basic_accept_hold",  16'(out_data), 16'h00A5);

    // Parity and framing errors still deliver the word
    send_frame(8'hA5, 1'b1, 1'b1, 0);
    check("err_valid", 16'(out_valid), 16'h1);
    check("err_data",  16'(out_data), 16'h00A5);
    check("err_perr",  16'(out_perr), 16'h1);
    check("err_ferr",  16'(out_ferr), 16'h1);
    idle(1);

    // Odd-weight word with correct parity bit 1
    out_ready = 1'b0;
    send_frame(8'h07, 1'b1, 1'b0, 0);
    check("odd_data", 16'(out_data), 16'h0007);
    check("odd_perr", 16'(out_perr), 16'h0);
    out_ready = 1'b1;
    idle(1);
    check("odd_accept", 16'(out_valid), 16'h0);

    // Overrun: second back-to-back frame dropped while buffer is full
    out_ready = 1'b0;
    send_frame(8'h3C, 1'b0, 1'b0, 0);
    check("ovr_first_data", 16'(out_data), 16'h003C);
    send_frame(8'hF0, 1'b0, 1'b0, 0);
    check("ovr_pulse", 16'(ovr), 16'h1);
    check("ovr_hold_data", 16'(out_data), 16'h003C);
    check("ovr_hold_valid", 16'(out_valid), 16'h1);
    idle(1);
    check("ovr_pulse_end", 16'(ovr), 16'h0);
    out_ready = 1'b1;
    idle(1);
    check("ovr_accept_valid", 16'(out_valid), 16'h0);
    check("ovr_accept_data",  16'(out_data), 16'h003C);

    // Ready rises on the very edge the second frame completes
    out_ready = 1'b0;
    send_frame(8'h3C, 1'b0, 1'b0, 0);
    send_body(8'hF0, 1'b0, 0);
    out_ready = 1'b1;
    send_bit(1'b0, 0);
    check("sim_data",  16'(out_data), 16'h00F0);
    check("sim_valid", 16'(out_valid), 16'h1);
    check("sim_ovr",   16'(ovr), 16'h0);
    idle(1);
    check("sim_accept", 16'(out_valid), 16'h0);

    // Stalled bit strobe: 1 of 3 cycles, garbage on the line in between
    out_ready = 1'b0;
    send_frame(8'hA5, 1'b0, 1'b0, 2);
    check("stall_valid", 16'(out_valid), 16'h1);
    check("stall_data",  16'(out_data), 16'h00A5);
    check("stall_perr",  16'(out_perr), 16'h0);
    check("stall_ferr",  16'(out_ferr), 16'h0);
    check("stall_busy",  16'(busy), 16'h0);
    out_ready = 1'b1;
    idle(1);

    // Reset mid-frame with a word held in the buffer
    out_ready = 1'b0;
    send_frame(8'hA5, 1'b0, 1'b0, 0);
    send_bit(1'b1, 0);
    send_bit(1'b1, 0); send_bit(1'b1, 0); send_bit(1'b0, 0); send_bit(1'b1, 0);
    #2 rst = 1'b1;
    #1;
    check("mrst_data",  16'(out_data), 16'h00);
    check("mrst_valid", 16'(out_valid), 16'h0);
    check("mrst_busy",  16'(busy), 16'h0);
    check("mrst_ovr",   16'(ovr), 16'h0);
    bit_en = 1'b0;
    sin    = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    idle(1);
    send_frame(8'h5A, 1'b0, 1'b0, 0);
    check("post_valid", 16'(out_valid), 16'h1);
    check("post_data",  16'(out_data), 16'h005A);
    check("post_perr",  16'(out_perr), 16'h0);
    check("post_ferr",  16'(out_ferr), 16'h0);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
